// File: rtl/load_store_unit.sv
// load_store_unit
//   Bridges the execute stage and a byte-addressed, word-wide data memory.
//   One RV32I load or store is accepted at a time. The unit checks size,
//   alignment and range, sign/zero-extends loads, and performs sub-word
//   stores as a read-modify-write because the memory writes whole words.
//
// Ports
//   clock, reset_n        : rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready   : request handshake (ready only while idle)
//   req_we, req_funct3    : store/load select and RV32I size/sign encoding
//   req_addr, req_wdata   : byte address and right-aligned store data
//   resp_valid/resp_ready : response handshake
//   resp_rdata, resp_err  : extended load data (0 for stores/errors), error
//   mem_addr, mem_wen     : memory address and one-cycle write strobe
//   mem_wdata, mem_rdata  : write word out, combinational read word in
module load_store_unit #(
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    RMW_READ = 3'd2,
    WRITE    = 3'd3,
    RESP     = 3'd4
  } state_t;

  // One past the last legal byte index, widened so addr + size cannot wrap.
  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

  state_t            state_q, state_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  // Holds the store data from accept, then the merged word after RMW_READ.
  logic [31:0]       merge_q, merge_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [2:0]        size_s;
  logic              illegal_s;
  logic              misaligned_s;
  logic              out_of_range_s;
  logic              req_err_s;
  logic [ADDR_W:0]   end_s;
  logic [ADDR_W-1:0] word_base_s;

  // Extend the addressed byte/half/word of a read word per funct3.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] w);
    logic [31:0] r;
    case (f3)
      3'b000:  r = {{24{w[7]}}, w[7:0]};
      3'b001:  r = {{16{w[15]}}, w[15:0]};
      3'b010:  r = w;
      3'b100:  r = {24'h000000, w[7:0]};
      3'b101:  r = {16'h0000, w[15:0]};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Overwrite the target lane(s) of the old word with the store data.
  function automatic logic [31:0] merge_lanes(input logic [1:0] sz, input logic [1:0] off,
                                              input logic [31:0] old_w, input logic [31:0] wd);
    logic [31:0] r;
    r = old_w;
    case (sz)
      2'b00:   r[{off, 3'b000} +: 8] = wd[7:0];
      2'b01:   r[{off[1], 4'b0000} +: 16] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  // Decode the incoming request: size, legality, alignment and range.
  always_comb begin
    case (req_funct3[1:0])
      2'b00:   size_s = 3'd1;
      2'b01:   size_s = 3'd2;
      2'b10:   size_s = 3'd4;
      default: size_s = 3'd4;
    endcase
    illegal_s = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                (req_funct3 == 3'b111) || (req_we && req_funct3[2]);
    case (req_funct3[1:0])
      2'b00:   misaligned_s = 1'b0;
      2'b01:   misaligned_s = req_addr[0];
      2'b10:   misaligned_s = |req_addr[1:0];
      default: misaligned_s = 1'b0;
    endcase
    end_s          = {1'b0, req_addr} + {{(ADDR_W-2){1'b0}}, size_s};
    out_of_range_s = end_s > MEM_LIMIT;
    req_err_s      = illegal_s || misaligned_s || out_of_range_s;
  end

  // Next-state and datapath updates for the access sequence.
  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    merge_d  = merge_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          funct3_d = req_funct3;
          addr_d   = req_addr;
          rdata_d  = 32'h0000_0000;
          err_d    = req_err_s;
          if (req_we) begin
            merge_d = req_wdata;
          end else begin
            merge_d = merge_q;
          end
          if (req_err_s) begin
            state_d = RESP;
          end else if (!req_we) begin
            state_d = LOAD;
          end else if (req_funct3[1:0] == 2'b10) begin
            state_d = WRITE;
          end else begin
            state_d = RMW_READ;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        rdata_d = load_extend(funct3_q, mem_rdata);
        state_d = RESP;
      end
      RMW_READ: begin
        merge_d = merge_lanes(funct3_q[1:0], addr_q[1:0], mem_rdata, merge_q);
        state_d = WRITE;
      end
      WRITE: begin
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched request registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      merge_q  <= 32'h0000_0000;
      rdata_q  <= 32'h0000_0000;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      merge_q  <= merge_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign word_base_s = {addr_q[ADDR_W-1:2], 2'b00};

  // Output decode; every output is a pure function of registered state.
  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
    mem_wen    = (state_q == WRITE);
    resp_rdata = rdata_q;
    resp_err   = err_q;
    mem_wdata  = merge_q;
    case (state_q)
      RMW_READ: mem_addr = word_base_s;
      WRITE: begin
        // SW is already aligned; SB/SH write back the whole containing word.
        if (funct3_q[1:0] == 2'b10) begin
          mem_addr = addr_q;
        end else begin
          mem_addr = word_base_s;
        end
      end
      default: mem_addr = addr_q;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Self-checking bench for load_store_unit. A byte-array memory answers the
//   unit's word reads and writes. Each scenario task pushes the expected
//   response into a scoreboard queue when it drives a request and pops it
//   when the unit responds.
module tb_load_store_unit;

  localparam int ADDR_W    = 32;
  localparam int MEM_BYTES = 64;

  logic              clock;
  logic              reset_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          wens;
    logic [31:0] waddr;
    logic [31:0] wdata;
  } txn_t;

  txn_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [7:0] mem_b [0:MEM_BYTES-1];
  logic       init_mem;

  load_store_unit #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Initial contents: byte i = i, except word 0x10 = 0x8899AABB.
  function automatic logic [7:0] init_byte(input int i);
    case (i)
      16:      return 8'hBB;
      17:      return 8'hAA;
      18:      return 8'h99;
      19:      return 8'h88;
      default: return 8'(i);
    endcase
  endfunction

  // Combinational read: byte at mem_addr+k on lane k, 0 beyond the array.
  always_comb begin
    logic [31:0] idx;
    mem_rdata = 32'h0;
    for (int k = 0; k < 4; k++) begin
      idx = mem_addr + 32'(k);
      if (idx < 32'(MEM_BYTES)) mem_rdata[8*k +: 8] = mem_b[idx[5:0]];
    end
  end

  // Memory initialisation and word writes.
  always @(posedge clock) begin
    logic [31:0] idx;
    if (init_mem) begin
      for (int i = 0; i < MEM_BYTES; i++) mem_b[i] <= init_byte(i);
    end else if (mem_wen === 1'b1) begin
      for (int k = 0; k < 4; k++) begin
        idx = mem_addr + 32'(k);
        if (idx < 32'(MEM_BYTES)) mem_b[idx[5:0]] <= mem_wdata[8*k +: 8];
      end
    end
  end

  function automatic txn_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] rd, input logic er,
                              input int lat, input int wens, input logic [31:0] waddr,
                              input logic [31:0] wdata);
    txn_t t;
    t.we = we; t.f3 = f3; t.addr = addr; t.wd = wd; t.rd = rd; t.er = er;
    t.lat = lat; t.wens = wens; t.waddr = waddr; t.wdata = wdata;
    return t;
  endfunction

  // Drive one request, wait (bounded) for resp_valid with resp_ready low.
  // lat counts negedges after the accept edge; -1 means no response.
  task automatic issue(input txn_t t, output logic [31:0] rd, output logic er,
                       output int lat, output int wens, output logic [31:0] waddr,
                       output logic [31:0] wdat);
    rd = 32'h0; er = 1'b0; lat = -1; wens = 0; waddr = 32'h0; wdat = 32'h0;
    @(negedge clock);
    req_valid = 1'b1; req_we = t.we; req_funct3 = t.f3; req_addr = t.addr; req_wdata = t.wd;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if (mem_wen === 1'b1) begin
        wens++; waddr = mem_addr; wdat = mem_wdata;
      end
      if (resp_valid === 1'b1) begin
        lat = c;
        break;
      end
    end
    rd = resp_rdata; er = resp_err;
  endtask

  task automatic complete();
    resp_ready = 1'b1;
    @(posedge clock);
    #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; init_mem = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0;
    req_wdata = 32'h0; resp_ready = 1'b0;
    repeat (3) @(negedge clock);
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
    n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
    n_tests++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_resp_rdata got %h exp 0", resp_rdata); end
    n_tests++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_resp_err got %b exp 0", resp_err); end
    n_tests++; if (mem_wen !== 1'b0) begin n_fail++; $display("FAIL reset_mem_wen got %b exp 0", mem_wen); end
    n_tests++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
    n_tests++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata got %h exp 0", mem_wdata); end
    init_mem = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic test_loads();
    txn_t tab[$];
    txn_t e;
    logic [31:0] rd, wa, wdt;
    logic er;
    int lat, wens;
    tab.push_back(mk(1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFF_FF88, 1'b0, 2, 0, 32'h0, 32'h0));
    tab.push_back(mk(1'b0, 3'b100, 32'h13, 32'h0, 32'h0000_0088, 1'b0, 2, 0, 32'h0, 32'h0));
    tab.push_back(mk(1'b0, 3'b010, 32'h10, 32'h0, 32'h8899_AABB, 1'b0, 2, 0, 32'h0, 32'h0));
    tab.push_back(mk(1'b0, 3'b001, 32'h10, 32'h0, 32'hFFFF_AABB, 1'b0, 2, 0, 32'h0, 32'h0));
    tab.push_back(mk(1'b0, 3'b101, 32'h12, 32'h0, 32'h0000_8899, 1'b0, 2, 0, 32'h0, 32'h0));
    tab.push_back(mk(1'b0, 3'b100, 32'h3F, 32'h0, 32'h0000_003F, 1'b0, 2, 0, 32'h0, 32'h0));
    tab.push_back(mk(1'b0, 3'b000, 32'h01, 32'h0, 32'h0000_0001, 1'b0, 2, 0, 32'h0, 32'h0));
    foreach (tab[i]) begin
      sb_q.push_back(tab[i]);
      issue(tab[i], rd, er, lat, wens, wa, wdt);
      e = sb_q.pop_front();
      n_tests++;
      if (rd !== e.rd || er !== e.er || lat != e.lat || wens != e.wens) begin
        n_fail++;
        $display("FAIL load f3=%b addr=%h: got rdata=%h err=%b lat=%0d wen=%0d, exp rdata=%h err=%b lat=%0d wen=%0d",
                 e.f3, e.addr, rd, er, lat, wens, e.rd, e.er, e.lat, e.wens);
      end
      complete();
    end
  endtask

  task automatic test_backpressure();
    txn_t t, e;
    logic [31:0] rd, wa, wdt;
    logic er;
    int lat, wens, bad;
    t = mk(1'b0, 3'b010, 32'h10, 32'h0, 32'h8899_AABB, 1'b0, 2, 0, 32'h0, 32'h0);
    sb_q.push_back(t);
    issue(t, rd, er, lat, wens, wa, wdt);
    e = sb_q.pop_front();
    n_tests++;
    if (rd !== e.rd || er !== e.er || lat != e.lat) begin
      n_fail++;
      $display("FAIL bp_first got rdata=%h err=%b lat=%0d exp rdata=%h err=%b lat=%0d",
               rd, er, lat, e.rd, e.er, e.lat);
    end
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0; req_wdata = 32'hFFFF_FFFF;
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clock);
      bad = (resp_valid !== 1'b1 || resp_rdata !== 32'h8899_AABB || resp_err !== 1'b0 ||
             req_ready !== 1'b0 || mem_wen !== 1'b0) ? 1 : 0;
      n_tests++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d] got valid=%b rdata=%h err=%b req_ready=%b wen=%b exp 1 8899aabb 0 0 0",
                 c, resp_valid, resp_rdata, resp_err, req_ready, mem_wen);
      end
    end
    req_valid = 1'b0;
    complete();
    @(negedge clock);
    n_tests++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release got req_ready=%b resp_valid=%b exp 1 0", req_ready, resp_valid);
    end
    n_tests++;
    if (mem_b[0] !== 8'h00) begin
      n_fail++;
      $display("FAIL bp_ignored_req got mem[0]=%h exp 00", mem_b[0]);
    end
  endtask

  task automatic test_stores();
    txn_t tab[$];
    txn_t e;
    logic [31:0] rd, wa, wdt;
    logic er;
    int lat, wens;
    tab.push_back(mk(1'b1, 3'b000, 32'h11, 32'h1234_5677, 32'h0, 1'b0, 3, 1, 32'h10, 32'h8899_77BB));
    tab.push_back(mk(1'b0, 3'b010, 32'h10, 32'h0, 32'h8899_77BB, 1'b0, 2, 0, 32'h0, 32'h0));
    tab.push_back(mk(1'b1, 3'b001, 32'h12, 32'h0000_CAFE, 32'h0, 1'b0, 3, 1, 32'h10, 32'hCAFE_77BB));
    tab.push_back(mk(1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF_CAFE, 1'b0, 2, 0, 32'h0, 32'h0));
    tab.push_back(mk(1'b0, 3'b101, 32'h12, 32'h0, 32'h0000_CAFE, 1'b0, 2, 0, 32'h0, 32'h0));
    tab.push_back(mk(1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 1, 32'h20, 32'hDEAD_BEEF));
    tab.push_back(mk(1'b0, 3'b010, 32'h20, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 0, 32'h0, 32'h0));
    tab.push_back(mk(1'b1, 3'b000, 32'h3F, 32'h0000_00A5, 32'h0, 1'b0, 3, 1, 32'h3C, 32'hA53E_3D3C));
    tab.push_back(mk(1'b0, 3'b000, 32'h3F, 32'h0, 32'hFFFF_FFA5, 1'b0, 2, 0, 32'h0, 32'h0));
    tab.push_back(mk(1'b1, 3'b001, 32'h3E, 32'h0000_1234, 32'h0, 1'b0, 3, 1, 32'h3C, 32'h1234_3D3C));
    tab.push_back(mk(1'b0, 3'b010, 32'h3C, 32'h0, 32'h1234_3D3C, 1'b0, 2, 0, 32'h0, 32'h0));
    foreach (tab[i]) begin
      sb_q.push_back(tab[i]);
      issue(tab[i], rd, er, lat, wens, wa, wdt);
      e = sb_q.pop_front();
      n_tests++;
      if (rd !== e.rd || er !== e.er || lat != e.lat || wens != e.wens ||
          (e.wens > 0 && (wa !== e.waddr || wdt !== e.wdata))) begin
        n_fail++;
        $display("FAIL store_seq[%0d] we=%b addr=%h: got rdata=%h err=%b lat=%0d wen=%0d waddr=%h wdata=%h, exp rdata=%h err=%b lat=%0d wen=%0d waddr=%h wdata=%h",
                 i, e.we, e.addr, rd, er, lat, wens, wa, wdt, e.rd, e.er, e.lat, e.wens, e.waddr, e.wdata);
      end
      complete();
    end
  endtask

  task automatic test_errors();
    txn_t tab[$];
    txn_t e;
    logic [31:0] rd, wa, wdt;
    logic er;
    int lat, wens;
    tab.push_back(mk(1'b0, 3'b010, 32'h02, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0));
    tab.push_back(mk(1'b1, 3'b010, 32'h40, 32'h1111_1111, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0));
    tab.push_back(mk(1'b0, 3'b011, 32'h00, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0));
    tab.push_back(mk(1'b1, 3'b100, 32'h00, 32'h2222_2222, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0));
    tab.push_back(mk(1'b1, 3'b101, 32'h00, 32'h2222_2222, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0));
    tab.push_back(mk(1'b0, 3'b110, 32'h00, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0));
    tab.push_back(mk(1'b0, 3'b111, 32'h00, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0));
    tab.push_back(mk(1'b0, 3'b001, 32'h3F, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0));
    tab.push_back(mk(1'b0, 3'b010, 32'h3D, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0));
    tab.push_back(mk(1'b0, 3'b000, 32'h40, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0));
    tab.push_back(mk(1'b1, 3'b001, 32'h41, 32'h3333_3333, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0));
    tab.push_back(mk(1'b0, 3'b010, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0));
    foreach (tab[i]) begin
      sb_q.push_back(tab[i]);
      issue(tab[i], rd, er, lat, wens, wa, wdt);
      e = sb_q.pop_front();
      n_tests++;
      if (rd !== e.rd || er !== e.er || lat != e.lat || wens != e.wens) begin
        n_fail++;
        $display("FAIL err[%0d] we=%b f3=%b addr=%h: got rdata=%h err=%b lat=%0d wen=%0d, exp rdata=%h err=%b lat=%0d wen=%0d",
                 i, e.we, e.f3, e.addr, rd, er, lat, wens, e.rd, e.er, e.lat, e.wens);
      end
      complete();
    end
  endtask

  task automatic test_reset_mid_write();
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h05; req_wdata = 32'h0000_00AB;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    @(negedge clock);  // RMW_READ
    @(negedge clock);  // WRITE
    n_tests++;
    if (mem_wen !== 1'b1 || mem_addr !== 32'h04 || mem_wdata !== 32'h0706_AB04) begin
      n_fail++;
      $display("FAIL rst_mid_in_write got wen=%b addr=%h wdata=%h exp 1 00000004 0706ab04",
               mem_wen, mem_addr, mem_wdata);
    end
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (mem_wen !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_wen_drop got %b exp 0", mem_wen);
    end
    @(posedge clock);
    #1;
    n_tests++;
    if (mem_b[5] !== 8'h05) begin
      n_fail++;
      $display("FAIL rst_mid_mem_unchanged got %h exp 05", mem_b[5]);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    n_tests++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_release got req_ready=%b resp_valid=%b exp 1 0", req_ready, resp_valid);
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_backpressure();
    test_stores();
    test_errors();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the core's execute stage and the byte-addressed data memory.
- Accepts one RV32I load or store per request and resolves size, sign extension, alignment and range checks.
- Memory only writes full 32-bit words, so sub-word stores are done as read-modify-write.
- Returns load data or an error flag through a valid/ready response handshake.

Parameters:
- ADDR_W, 32, width of request and memory address.
- MEM_BYTES, 64, memory size in bytes. Any access touching byte index >= MEM_BYTES is an error.

Ports:
- clock  input  1  single system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request (high only in IDLE).
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I funct3: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data, right-aligned.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts response.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  misaligned, out-of-range, or illegal funct3.
- mem_addr  output  ADDR_W  word access address into memory.
- mem_wen  output  1  memory write enable (memory samples on posedge).
- mem_wdata  output  32  write word; byte at mem_addr+k is mem_wdata[8k+:8].
- mem_rdata  input  32  combinational read word; byte at mem_addr+k is mem_rdata[8k+:8].

Behaviour:
- Reset (async, while reset_n=0):
  - State goes to IDLE.
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_wen=0, mem_addr=0, mem_wdata=0.
  - All latched request fields are cleared.
- Reset mid-operation aborts the access.
  - mem_wen drops immediately; it is decoded from state only.
  - A half-done read-modify-write writes nothing.
- States: IDLE, LOAD, RMW_READ, WRITE, RESP.
- IDLE:
  - On req_valid & req_ready, latch we, funct3, addr and wdata.
  - Size: 1 for x00, 2 for x01, 4 for 010.
  - Error if any of:
    - funct3 is 011, 110 or 111;
    - store with funct3[2]=1;
    - addr not aligned to size;
    - addr + size > MEM_BYTES.
  - Next state: error -> RESP with resp_err=1; load -> LOAD; SW -> WRITE with merge word = wdata; SB/SH -> RMW_READ.
- LOAD:
  - mem_addr = addr.
  - Capture byte/half/word from mem_rdata[7:0] / [15:0] / [31:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Next state: RESP.
- RMW_READ:
  - mem_addr = addr & ~3 (word base).
  - Capture mem_rdata and overwrite the target lane(s) with wdata[7:0] or wdata[15:0] at byte offset addr[1:0].
  - Next state: WRITE.
- WRITE:
  - mem_addr = word base for SB/SH, addr for SW.
  - mem_wen=1 for exactly this one cycle; mem_wdata = merge word.
  - Next state: RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_err stay stable until resp_ready.
  - Transition to IDLE on resp_valid & resp_ready.
  - No new request is accepted in the same cycle (req_ready=0 in RESP).
- Latency, with request accepted at edge N:
  - Error: resp_valid at N+1.
  - Load or SW: resp_valid at N+2.
  - SB/SH: resp_valid at N+3.
- Throughput: one outstanding request. req_valid outside IDLE is ignored.
- mem_addr outside LOAD/RMW_READ/WRITE holds the last latched address. mem_wen is never high in any state other than WRITE.
- An SB/SH word base with addr[1:0] near MEM_BYTES-4..MEM_BYTES-1 is legal when the range check passes.

Test Plan:
- Memory word at 0x10 = 0x8899AABB (byte 0x10 = 0xBB); LB 0x13 -> resp_rdata=0xFFFFFF88, err=0, resp_valid 2 cycles after accept. LBU 0x13 -> 0x00000088.
- SB 0x11, wdata=0x12345677 -> one mem_wen pulse at mem_addr=0x10 with mem_wdata=0x8899_77BB; resp_valid 3 cycles after accept; LW 0x10 then returns 0x889977BB.
- SH 0x12, wdata=0x0000CAFE -> word becomes 0xCAFEAABB. LH 0x12 -> 0xFFFFCAFE; LHU 0x12 -> 0x0000CAFE.
- Errors, each giving resp_err=1 one cycle after accept with no mem_wen pulse:
  - LW 0x02 (misaligned);
  - SW 0x40 with MEM_BYTES=64 (out of range);
  - load funct3=011 (illegal);
  - store funct3=100 (illegal).
- Hold resp_ready=0 for 5 cycles on a load -> resp_valid, resp_rdata and resp_err stay stable and req_ready stays 0. A req_valid pulse during this window is not accepted and causes no memory access.
- Drop reset_n during WRITE of an SB -> mem_wen=0 immediately, memory unchanged. After release, req_ready=1 and resp_valid=0.
